// File: rtl/trace_capture.sv
// Logic-analyzer style trace capture: CH programmable bit selects from a wide bus,
// a level trigger on one channel, and a DEPTH-entry capture buffer drained by a ready/valid reader.
module trace_capture #(
    parameter int DATA_W = 256,
    parameter int SEL_W  = 9,
    parameter int CH     = 4,
    parameter int DEPTH  = 16
) (
    input  logic                    clk,
    input  logic                    reset_L,
    input  logic [DATA_W-1:0]       d,
    input  logic                    req_valid,
    input  logic [7:0]              bRequest,
    input  logic [15:0]             parameter_Block16,
    output logic [CH-1:0]           q,
    output logic [CH*SEL_W-1:0]     actual_select,
    output logic [CH-1:0]           rd_data,
    output logic                    rd_valid,
    input  logic                    rd_ready,
    output logic [1:0]              state,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [7:0] CMD_SET_SEL = 8'h01;
    localparam logic [7:0] CMD_ARM     = 8'h02;
    localparam logic [7:0] CMD_ABORT   = 8'h03;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t            state_r, state_next;
    logic [SEL_W-1:0]  sel [CH];
    logic [3:0]        trig_ch;
    logic              trig_lvl;
    logic              trig_hit;
    logic [CH-1:0]     q_next;
    logic [CH-1:0]     q_shift;
    logic [CW-1:0]     cnt_r, cnt_next;
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [CH-1:0]     mem [DEPTH];
    logic              wr_en, rd_en, set_sel, arm, clr;
    logic [3:0]        cmd_ch;
    logic              ch_ok, cmd_abort;
    logic              unused_cmd_bits;

    // A shift past the top of the bus yields zero, which covers out-of-range selects.
    function automatic logic pick_bit(input logic [DATA_W-1:0] bus, input logic [SEL_W-1:0] idx);
        logic [DATA_W-1:0] shifted;
        shifted = bus >> idx;
        return shifted[0];
    endfunction

    assign cmd_ch          = parameter_Block16[15:12];
    assign ch_ok           = ({28'd0, cmd_ch} < 32'(CH));
    assign cmd_abort       = req_valid && (bRequest == CMD_ABORT);
    assign unused_cmd_bits = ^parameter_Block16;

    always_comb begin
        for (int k = 0; k < CH; k++) begin
            q_next[k] = pick_bit(d, sel[k]);
        end
    end

    always_comb begin
        q_shift  = q >> trig_ch;
        trig_hit = (q_shift[0] == trig_lvl);
    end

    // Stage p0: selected bits, select table and trigger setup
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            q        <= '0;
            trig_ch  <= '0;
            trig_lvl <= 1'b0;
            for (int k = 0; k < CH; k++) begin
                sel[k] <= SEL_W'(k);
            end
        end else begin
            q <= q_next;
            if (set_sel) begin
                for (int k = 0; k < CH; k++) begin
                    if (cmd_ch == 4'(k)) begin
                        sel[k] <= parameter_Block16[SEL_W-1:0];
                    end
                end
            end
            if (arm) begin
                trig_ch  <= cmd_ch;
                trig_lvl <= parameter_Block16[8];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next;
        end
    end

    // ABORT overrides everything, including a pop or trigger on the same edge.
    always_comb begin
        state_next = state_r;
        cnt_next   = cnt_r;
        wr_en      = 1'b0;
        rd_en      = 1'b0;
        set_sel    = 1'b0;
        arm        = 1'b0;
        clr        = 1'b0;
        if (cmd_abort) begin
            state_next = IDLE;
            cnt_next   = '0;
            clr        = 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    if (req_valid && bRequest == CMD_SET_SEL && ch_ok) begin
                        set_sel = 1'b1;
                    end
                    if (req_valid && bRequest == CMD_ARM && ch_ok) begin
                        arm        = 1'b1;
                        state_next = ARMED;
                    end
                end
                ARMED: begin
                    if (trig_hit) begin
                        wr_en      = 1'b1;
                        cnt_next   = CW'(1);
                        state_next = CAPTURE;
                    end
                end
                CAPTURE: begin
                    wr_en    = 1'b1;
                    cnt_next = cnt_r + CW'(1);
                    if (cnt_r == CW'(DEPTH - 1)) begin
                        state_next = DONE;
                    end
                end
                DONE: begin
                    if (rd_valid && rd_ready) begin
                        rd_en    = 1'b1;
                        cnt_next = cnt_r - CW'(1);
                        if (cnt_r == CW'(1)) begin
                            state_next = IDLE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Stage p1: buffer occupancy and pointers
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            cnt_r  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            cnt_r <= cnt_next;
            if (clr) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (wr_en) wr_ptr <= wr_ptr + AW'(1);
                if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= q;
        end
    end

    for (genvar k = 0; k < CH; k++) begin : g_sel_out
        assign actual_select[k*SEL_W +: SEL_W] = sel[k];
    end

    assign rd_data  = mem[rd_ptr];
    assign rd_valid = (state_r == DONE) && (cnt_r != '0);
    assign state    = state_r;
    assign count    = cnt_r;

endmodule

// File: tb/tb_trace_capture.sv
// Directed bench for trace_capture: select table, capture/drain, backpressure,
// illegal commands, abort and asynchronous reset.
module tb_trace_capture;

    localparam int DATA_W = 256;
    localparam int SEL_W  = 9;
    localparam int CH     = 4;
    localparam int DEPTH  = 16;

    logic                   clk = 1'b0;
    logic                   reset_L;
    logic [DATA_W-1:0]      d;
    logic                   req_valid;
    logic [7:0]             bRequest;
    logic [15:0]            parameter_Block16;
    logic [CH-1:0]          q;
    logic [CH*SEL_W-1:0]    actual_select;
    logic [CH-1:0]          rd_data;
    logic                   rd_valid;
    logic                   rd_ready;
    logic [1:0]             state;
    logic [4:0]             count;

    trace_capture #(.DATA_W(DATA_W), .SEL_W(SEL_W), .CH(CH), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .reset_L(reset_L),
        .d(d),
        .req_valid(req_valid),
        .bRequest(bRequest),
        .parameter_Block16(parameter_Block16),
        .q(q),
        .actual_select(actual_select),
        .rd_data(rd_data),
        .rd_valid(rd_valid),
        .rd_ready(rd_ready),
        .state(state),
        .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0]       prm;
        logic [DATA_W-1:0] dv;
        logic [3:0]        eq;
        int                s0, s1, s2, s3;
    } sel_vec_t;

    int          checks = 0;
    int          failures = 0;
    int          es [4];
    logic [3:0]  expq [16];
    sel_vec_t    tbl [9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic [7:0] code, input logic [15:0] prm);
        req_valid = 1'b1;
        bRequest = code;
        parameter_Block16 = prm;
        tick();
        req_valid = 1'b0;
        bRequest = 8'h00;
        parameter_Block16 = 16'h0000;
    endtask

    function automatic logic [35:0] pack4(input int a, input int b, input int c, input int e);
        return {9'(e), 9'(c), 9'(b), 9'(a)};
    endfunction

    function automatic logic [3:0] qmodel(input logic [DATA_W-1:0] dv);
        logic [3:0] r;
        for (int k = 0; k < 4; k++) begin
            r[k] = (es[k] < DATA_W) ? dv[es[k]] : 1'b0;
        end
        return r;
    endfunction

    function automatic logic [3:0] nib(input int i);
        return 4'(15 + 7 * i);
    endfunction

    // ARM on channel 1 level 1, trigger on sample 0, capture DEPTH samples, hold, then drain.
    task automatic capture_run(input string tag, input int hold);
        d = '0;
        cmd(8'h02, 16'h1100);
        chk({tag, " armed"}, 64'(state), 64'd1);
        tick();
        tick();
        chk({tag, " still armed"}, 64'(state), 64'd1);
        for (int i = 0; i <= DEPTH; i++) begin
            d = '0;
            d[3:0] = nib(i);
            if (i < DEPTH) expq[i] = qmodel(d);
            tick();
            if (i == 0) begin
                chk({tag, " trig q1"}, 64'(q[1]), 64'd1);
                chk({tag, " trig edge state"}, 64'(state), 64'd1);
            end else begin
                chk($sformatf("%s cap count %0d", tag, i), 64'(count), 64'(i));
                chk($sformatf("%s cap state %0d", tag, i), 64'(state), (i < DEPTH) ? 64'd2 : 64'd3);
            end
        end
        d = '0;
        rd_ready = 1'b0;
        for (int h = 0; h < hold; h++) begin
            chk($sformatf("%s hold rd_valid %0d", tag, h), 64'(rd_valid), 64'd1);
            chk($sformatf("%s hold rd_data %0d", tag, h), 64'(rd_data), 64'(expq[0]));
            chk($sformatf("%s hold count %0d", tag, h), 64'(count), 64'd16);
            tick();
        end
        rd_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            chk($sformatf("%s pop data %0d", tag, i), 64'(rd_data), 64'(expq[i]));
            if (i == DEPTH - 1) chk({tag, " last pop state"}, 64'(state), 64'd3);
            tick();
        end
        rd_ready = 1'b0;
        chk({tag, " drained state"}, 64'(state), 64'd0);
        chk({tag, " drained count"}, 64'(count), 64'd0);
        chk({tag, " drained rd_valid"}, 64'(rd_valid), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DATA_W-1:0] ones;
        logic [DATA_W-1:0] one;
        logic [35:0]       sel_snap;
        ones = '1;
        one = '0;
        one[0] = 1'b1;
        tbl[0] = '{16'h0105, ones,               4'b1110, 261, 1, 2, 3};
        tbl[1] = '{16'h00FF, ones,               4'b1111, 255, 1, 2, 3};
        tbl[2] = '{16'h1000, one << 255,         4'b0001, 255, 0, 2, 3};
        tbl[3] = '{16'h2080, (one << 128) | one, 4'b0110, 255, 0, 128, 3};
        tbl[4] = '{16'h31FF, ones,               4'b0111, 255, 0, 128, 511};
        tbl[5] = '{16'h5003, 256'hA,             4'b0000, 255, 0, 128, 511};
        tbl[6] = '{16'h3100, ones,               4'b0111, 255, 0, 128, 256};
        tbl[7] = '{16'h30FE, one << 254,         4'b1000, 255, 0, 128, 254};
        tbl[8] = '{16'h0E05, one << 5,           4'b0001, 5, 0, 128, 254};

        d = '0;
        req_valid = 1'b0;
        bRequest = 8'h00;
        parameter_Block16 = 16'h0000;
        rd_ready = 1'b0;
        reset_L = 1'b1;
        #1 reset_L = 1'b0;
        #1;
        chk("reset state", 64'(state), 64'd0);
        chk("reset count", 64'(count), 64'd0);
        chk("reset q", 64'(q), 64'd0);
        chk("reset rd_valid", 64'(rd_valid), 64'd0);
        chk("reset sel", 64'(actual_select), 64'(pack4(0, 1, 2, 3)));
        #10 reset_L = 1'b1;

        for (int i = 0; i < 9; i++) begin
            d = tbl[i].dv;
            cmd(8'h01, tbl[i].prm);
            tick();
            chk($sformatf("selvec %0d q", i), 64'(q), 64'(tbl[i].eq));
            chk($sformatf("selvec %0d sel", i), 64'(actual_select),
                64'(pack4(tbl[i].s0, tbl[i].s1, tbl[i].s2, tbl[i].s3)));
        end

        d = '0;
        cmd(8'h01, 16'h0000);
        cmd(8'h01, 16'h1003);
        cmd(8'h01, 16'h2002);
        cmd(8'h01, 16'h3001);
        es = '{0, 3, 2, 1};
        chk("capture sels", 64'(actual_select), 64'(pack4(0, 3, 2, 1)));

        capture_run("cap", 5);

        sel_snap = actual_select;
        cmd(8'h02, 16'hF100);
        chk("arm ch15 state", 64'(state), 64'd0);
        cmd(8'h02, 16'h4100);
        chk("arm ch4 state", 64'(state), 64'd0);
        cmd(8'h7F, 16'h1005);
        chk("code 7f state", 64'(state), 64'd0);
        chk("code 7f sel", 64'(actual_select), 64'(sel_snap));
        bRequest = 8'h02;
        parameter_Block16 = 16'h1100;
        tick();
        bRequest = 8'h00;
        parameter_Block16 = 16'h0000;
        chk("no valid state", 64'(state), 64'd0);
        cmd(8'h02, 16'h1100);
        chk("arm ok", 64'(state), 64'd1);
        cmd(8'h01, 16'h1010);
        chk("setsel armed state", 64'(state), 64'd1);
        chk("setsel armed sel", 64'(actual_select), 64'(sel_snap));
        cmd(8'h03, 16'h0000);
        chk("abort armed", 64'(state), 64'd0);

        d = '0;
        cmd(8'h02, 16'h1100);
        d = ones;
        for (int n = 0; n < 40 && count != 5'd7; n++) tick();
        chk("abort cap count7", 64'(count), 64'd7);
        chk("abort cap state", 64'(state), 64'd2);
        cmd(8'h03, 16'h0000);
        chk("abort cap -> state", 64'(state), 64'd0);
        chk("abort cap -> count", 64'(count), 64'd0);

        d = '0;
        cmd(8'h02, 16'h1100);
        d = ones;
        for (int n = 0; n < 60 && state != 2'd3; n++) tick();
        chk("abortpop done", 64'(state), 64'd3);
        chk("abortpop full", 64'(count), 64'd16);
        rd_ready = 1'b1;
        tick();
        tick();
        tick();
        chk("abortpop after 3 pops", 64'(count), 64'd13);
        cmd(8'h03, 16'h0000);
        rd_ready = 1'b0;
        chk("abortpop count", 64'(count), 64'd0);
        chk("abortpop state", 64'(state), 64'd0);
        chk("abortpop rd_valid", 64'(rd_valid), 64'd0);

        d = '0;
        cmd(8'h02, 16'h1100);
        d = ones;
        for (int n = 0; n < 40 && count != 5'd5; n++) tick();
        chk("rst mid cap count", 64'(count), 64'd5);
        #3 reset_L = 1'b0;
        #1;
        chk("async rst state", 64'(state), 64'd0);
        chk("async rst count", 64'(count), 64'd0);
        chk("async rst q", 64'(q), 64'd0);
        chk("async rst rd_valid", 64'(rd_valid), 64'd0);
        chk("async rst sel", 64'(actual_select), 64'(pack4(0, 1, 2, 3)));
        #2 reset_L = 1'b1;
        d = '0;
        es = '{0, 1, 2, 3};
        capture_run("postrst", 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
